// File: rtl/spine_ingress_fifo_if.sv
// Spine ingress handshake bundle: upstream flit port plus head-of-line port toward the router.
// The master modport is the side that sources flits and consumes the head; slave is the FIFO.
interface spine_ingress_fifo_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic [5:0]        in_dest_addr;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic [5:0]        out_dest_addr;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_dest_addr, out_ready,
    input  in_ready, out_data, out_valid, out_dest_addr
  );

  modport slave (
    input  in_data, in_valid, in_dest_addr, out_ready,
    output in_ready, out_data, out_valid, out_dest_addr
  );
endinterface

// File: rtl/spine_ingress_fifo.sv
// Per-spine-link show-ahead ingress FIFO with full/empty status and saturating stall/drop counters.
// Optional macro SPINE_INGRESS_DEST_CHECK_EN discards flits whose destination group is not local.
module spine_ingress_fifo #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0011,
  parameter int         STALL_CW   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  spine_ingress_fifo_if.slave           bus,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [STALL_CW-1:0]           stall_count,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DWIDTH + 6;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_occ;
  logic [STALL_CW-1:0] r_stall_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_write;
  logic          w_stall;
  logic [EW-1:0] w_head;

  assign w_full  = (r_occ == DEPTH_C);
  assign w_empty = (r_occ == '0);

  // Handshake ready only depends on registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid & !w_full;
  assign w_pop        = !w_empty & bus.out_ready;
  assign w_stall      = bus.in_valid & w_full;

`ifdef SPINE_INGRESS_DEST_CHECK_EN
  logic       w_dest_ok;
  logic [7:0] r_drop_cnt;

  assign w_dest_ok = (bus.in_dest_addr[5:2] == GROUP_ID);
  assign w_write   = w_push & w_dest_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_push && !w_dest_ok && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign w_write    = w_push;
  assign drop_count = '0;
`endif

  // Storage is intentionally left unreset; validity is tracked purely by occupancy.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= {bus.in_dest_addr, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
    end
  end

  assign w_head            = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.out_valid     = !w_empty;
  assign bus.out_data      = w_head[DWIDTH-1:0];
  assign bus.out_dest_addr = w_head[EW-1:DWIDTH];

  assign fifo_full   = w_full;
  assign fifo_empty  = w_empty;
  assign occupancy   = r_occ;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_spine_ingress_fifo.sv
// Directed bench for spine_ingress_fifo: inputs change and outputs are sampled on the falling edge.
// Expected values are hand-derived; destination-check expectations follow SPINE_INGRESS_DEST_CHECK_EN.
module tb_spine_ingress_fifo;

  logic       clk;
  logic       reset;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] occupancy;
  logic [15:0] stall_count;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  spine_ingress_fifo_if #(.DWIDTH(16)) bus ();

  spine_ingress_fifo #(
    .DWIDTH(16), .FIFO_DEPTH(8), .GROUP_ID(4'b0011), .STALL_CW(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .occupancy   (occupancy),
    .stall_count (stall_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_dest_addr = '0;
    bus.out_ready    = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_occ",     32'(occupancy),     32'd0);
    chk("rst_empty",   32'(fifo_empty),    32'd1);
    chk("rst_full",    32'(fifo_full),     32'd0);
    chk("rst_ready",   32'(bus.in_ready),  32'd1);
    chk("rst_ovalid",  32'(bus.out_valid), 32'd0);
    chk("rst_odata",   32'(bus.out_data),  32'd0);
    chk("rst_odest",   32'(bus.out_dest_addr), 32'd0);
    chk("rst_stall",   32'(stall_count),   32'd0);
    chk("rst_drop",    32'(drop_count),    32'd0);
    reset = 1'b0;

    // Single flit, one-cycle latency, then pop
    bus.in_data = 16'hA5A5; bus.in_dest_addr = 6'b001101; bus.in_valid = 1'b1;
    chk("single_no_bypass", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("single_ovalid", 32'(bus.out_valid), 32'd1);
    chk("single_odata",  32'(bus.out_data),  32'hA5A5);
    chk("single_odest",  32'(bus.out_dest_addr), 32'b001101);
    chk("single_occ",    32'(occupancy), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_empty",  32'(fifo_empty),  32'd1);
    chk("single_odata0", 32'(bus.out_data), 32'd0);

    // Fill to full, stall three cycles, drain in order
    bus.in_dest_addr = 6'b001100;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 16'(i); bus.in_valid = 1'b1;
      step();
    end
    chk("fill_full",  32'(fifo_full),    32'd1);
    chk("fill_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_occ",   32'(occupancy),    32'd8);
    bus.in_data = 16'h0009;
    step(); step(); step();
    bus.in_valid = 1'b0;
    chk("stall_cnt3", 32'(stall_count), 32'd3);
    chk("stall_occ",  32'(occupancy),   32'd8);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(bus.out_data), 32'(i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Simultaneous push/pop at occupancy 4 with pointer wrap
    for (int k = 0; k < 4; k++) begin
      bus.in_data = 16'h0100 + 16'(k); bus.in_valid = 1'b1;
      step();
    end
    chk("pp_occ_start", 32'(occupancy), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_data = 16'h0104 + 16'(k);
      chk($sformatf("pp_data_%0d", k), 32'(bus.out_data), 32'h0100 + 32'(k));
      step();
      chk($sformatf("pp_occ_%0d", k), 32'(occupancy), 32'd4);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp_tail_%0d", k), 32'(bus.out_data), 32'h0114 + 32'(k));
      step();
    end
    bus.out_ready = 1'b0;
    chk("pp_empty", 32'(fifo_empty), 32'd1);

    // Full with out_ready and in_valid: pop only, push accepted next cycle
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 16'h0200 + 16'(k); bus.in_valid = 1'b1;
      step();
    end
    chk("fp_full", 32'(fifo_full), 32'd1);
    bus.in_data = 16'h02FF; bus.out_ready = 1'b1;
    step();
    chk("fp_occ7",   32'(occupancy),   32'd7);
    chk("fp_stall4", 32'(stall_count), 32'd4);
    chk("fp_ready",  32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("fp_occ8",      32'(occupancy),   32'd8);
    chk("fp_stall_hold", 32'(stall_count), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("fp_drain_%0d", k), 32'(bus.out_data), 32'h0200 + 32'(k));
      step();
    end
    chk("fp_drain_last", 32'(bus.out_data), 32'h02FF);
    step();
    bus.out_ready = 1'b0;
    chk("fp_empty", 32'(fifo_empty), 32'd1);

    // Reset mid-burst at occupancy 5
    bus.in_dest_addr = 6'b001101;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = 16'h0300 + 16'(k); bus.in_valid = 1'b1;
      step();
    end
    chk("mr_occ5", 32'(occupancy), 32'd5);
    bus.in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_occ0",   32'(occupancy),     32'd0);
    chk("mr_ovalid", 32'(bus.out_valid), 32'd0);
    chk("mr_stall",  32'(stall_count),   32'd0);
    chk("mr_empty",  32'(fifo_empty),    32'd1);
    bus.in_data = 16'h1234; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("mr_ovalid1", 32'(bus.out_valid), 32'd1);
    chk("mr_odata",   32'(bus.out_data),  32'h1234);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("mr_empty2", 32'(fifo_empty), 32'd1);

    // Destination group check
    bus.in_data = 16'hBEEF; bus.in_dest_addr = 6'b010000; bus.in_valid = 1'b1;
    step();
    bus.in_data = 16'hCAFE; bus.in_dest_addr = 6'b001110;
    step();
    bus.in_valid = 1'b0;
`ifdef SPINE_INGRESS_DEST_CHECK_EN
    chk("dc_drop",  32'(drop_count),   32'd1);
    chk("dc_occ",   32'(occupancy),    32'd1);
    chk("dc_odata", 32'(bus.out_data), 32'hCAFE);
    chk("dc_odest", 32'(bus.out_dest_addr), 32'b001110);
`else
    chk("dc_drop",  32'(drop_count),   32'd0);
    chk("dc_occ",   32'(occupancy),    32'd2);
    chk("dc_odata", 32'(bus.out_data), 32'hBEEF);
    chk("dc_odest", 32'(bus.out_dest_addr), 32'b010000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spine_ingress_fifo.md
Name: spine_ingress_fifo

Overview:
- Per-spine ingress buffer feeding one spine input port (data/valid/dest_addr) of a group leaf router.
- Absorbs spine-link bursts, presents head-of-line flits to the router crossbar, and exposes real full/empty status.
- Those status bits drive the router's spine_fifo_in_full / spine_fifo_in_empty buses.
- One instance per spine link: four per leaf router.

Parameters:
- DWIDTH, 16, flit payload width
- FIFO_DEPTH, 8, entries; power of two, minimum 2
- GROUP_ID, 4'b0011, local group number; compared against dest_addr[5:2]
- STALL_CW, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DWIDTH  flit from spine link
- in_valid  in  1  in_data/in_dest_addr valid
- in_dest_addr  in  6  destination address; [5:2] is the group, [1:0] is the local port
- in_ready  out  1  buffer can accept a flit this cycle
- out_data  out  DWIDTH  head flit to router spine input
- out_valid  out  1  head flit valid
- out_dest_addr  out  6  head destination address
- out_ready  in  1  router consumes the head flit this cycle
- fifo_full  out  1  occupancy == FIFO_DEPTH
- fifo_empty  out  1  occupancy == 0
- occupancy  out  $clog2(FIFO_DEPTH)+1  current entry count
- stall_count  out  STALL_CW  cycles with in_valid=1 and in_ready=0; saturating
- drop_count  out  8  flits discarded by the destination check; saturating; reads 0 when DEST_CHECK_EN is undefined

Behaviour:
- Single clock domain. All state updates on posedge clk. Synchronous active-high reset.
- Reset values:
  - read/write pointers and occupancy = 0
  - fifo_empty = 1, fifo_full = 0, in_ready = 1
  - out_valid = 0; out_data and out_dest_addr = 0
  - stall_count = 0, drop_count = 0
  - Storage array is not reset.
- Entry format: {dest_addr[5:0], data[DWIDTH-1:0]}.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = !fifo_full, combinational from registered occupancy. There is no push when full, even if a pop occurs the same cycle.
- Show-ahead output:
  - out_valid = !fifo_empty.
  - out_data and out_dest_addr are driven combinationally from mem[rd_ptr] when non-empty, and forced to 0 when empty.
- Latency: a flit pushed in cycle N appears on out_* in cycle N+1. There is no bypass path, including when the FIFO is empty.
- Occupancy update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (legal whenever 0 < occupancy < FIFO_DEPTH)
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- Pop when empty is impossible because out_valid=0. out_ready while empty is ignored.
- stall_count: increments each cycle with in_valid & !in_ready. Holds at all-ones.
- Ordering: strict FIFO; no reordering or flit modification.
- A flit held on in_* while in_ready=0 must be held by the sender. The buffer does not latch it.
- Reset mid-operation: all buffered flits are discarded. out_valid drops in the cycle after reset is sampled high.

Optional Feature:
- Macro: SPINE_INGRESS_DEST_CHECK_EN.
- Defined:
  - A flit with in_valid=1, in_ready=1 and in_dest_addr[5:2] != GROUP_ID is consumed (handshake completes) but not written.
  - drop_count increments, saturating at 8'hFF.
  - Occupancy and pointers are unchanged.
- Undefined:
  - Every handshaked flit is written.
  - drop_count is tied to 0 and no comparator is synthesized.

Test Plan:
- Reset then single flit: push in_data=16'hA5A5, dest=6'b001101 at cycle 1 → out_valid=1, out_data=16'hA5A5, out_dest_addr=6'b001101 in cycle 2. Pop with out_ready=1 → fifo_empty=1 next cycle.
- Fill to full: out_ready=0, push 8 flits 0x0001..0x0008 → fifo_full=1, in_ready=0, occupancy=8. Hold in_valid 3 more cycles → stall_count=3. Drain → outputs 0x0001..0x0008 in order.
- Simultaneous push/pop at occupancy 4: push and pop every cycle for 20 cycles → occupancy stays 4, pointer wrap exercised, output order matches input.
- Full with out_ready=1 and in_valid=1: pop occurs, no push that cycle → occupancy goes 8→7. Push accepted the next cycle.
- Reset mid-burst with occupancy 5: assert reset for one cycle → occupancy=0, out_valid=0, stall_count=0. A new push 16'h1234 appears on the output one cycle later.
- With SPINE_INGRESS_DEST_CHECK_EN: push dest=6'b010000 (group 4) then 6'b001110 (group 3) → drop_count=1, occupancy=1, out_data is the second flit. Without the macro: occupancy=2, drop_count=0.
